// File: rtl/img_sram_loader.sv
// Packs a bit-serial pixel stream into one SRAM word per image row and writes
// the header / row / end-of-job words that the binary convolution engine reads.
module img_sram_loader #(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [4:0]        load_dim,
    input  logic              load_end,
    input  logic              pix_valid,
    input  logic              pix_data,
    output logic              pix_ready,
    output logic              loader_busy,
    output logic              loader_done,
    output logic              err_dim,
    output logic              err_ovf,
    output logic [ADDR_W-1:0] loader_sram_write_address,
    output logic [DATA_W-1:0] loader_sram_write_data,
    output logic              loader_sram_write_enable
);

    localparam int                COL_W     = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] TERM_WORD = DATA_W'(16'h00FF);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_ROW, S_RWR, S_WAIT, S_TERM, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              full_q, full_d;
    logic [4:0]        n_q, n_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [DATA_W-1:0] pack_q, pack_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_dim_q, err_dim_d;
    logic              err_ovf_q, err_ovf_d;

    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              dim_ok;
    logic              xfer;

    assign dim_ok = (load_dim == 5'd10) || (load_dim == 5'd12) || (load_dim == 5'd16);
    assign xfer   = pix_valid && ready_q;

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        full_d    = full_q;
        n_d       = n_q;
        col_d     = col_q;
        row_d     = row_q;
        pack_d    = pack_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_dim_d = 1'b0;
        err_ovf_d = err_ovf_q;
        wr_req    = 1'b0;
        wr_data   = '0;

        case (state_q)
            S_IDLE, S_WAIT: begin
                if (load_end) begin
                    state_d = S_TERM;
                end else if (load_start) begin
                    if (dim_ok) begin
                        state_d = S_HDR;
                        n_d     = load_dim;
                    end else begin
                        err_dim_d = 1'b1;
                    end
                end
            end
            S_HDR: begin
                wr_req  = 1'b1;
                wr_data = DATA_W'(n_q);
                col_d   = '0;
                row_d   = '0;
                pack_d  = '0;
                state_d = S_ROW;
            end
            S_ROW: begin
                if (xfer) begin
                    pack_d[col_q] = pix_data;
                    col_d         = col_q + COL_W'(1);
                    if (5'(col_q) == n_q - 5'd1) state_d = S_RWR;
                end
            end
            S_RWR: begin
                wr_req  = 1'b1;
                wr_data = pack_q;
                pack_d  = '0;
                col_d   = '0;
                row_d   = row_q + 5'd1;
                state_d = (row_q == n_q - 5'd1) ? S_WAIT : S_ROW;
            end
            S_TERM: begin
                wr_req  = 1'b1;
                wr_data = TERM_WORD;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                ptr_d   = BASE_ADDR;
                full_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Once the top address has been written, any further write is dropped for good.
        if (wr_req) begin
            if (full_q || err_ovf_q) begin
                err_ovf_d = 1'b1;
            end else begin
                we_d   = 1'b1;
                addr_d = ptr_q;
                data_d = wr_data;
                ptr_d  = ptr_q + ADDR_W'(1);
                if (ptr_q == {ADDR_W{1'b1}}) full_d = 1'b1;
            end
        end
    end

    assign ready_d = (state_d == S_ROW);
    assign busy_d  = (state_d != S_IDLE);

    // NOTE: state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= BASE_ADDR;
            full_q    <= 1'b0;
            n_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            pack_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_dim_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            full_q    <= full_d;
            n_q       <= n_d;
            col_q     <= col_d;
            row_q     <= row_d;
            pack_q    <= pack_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_dim_q <= err_dim_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    assign pix_ready                 = ready_q;
    assign loader_busy               = busy_q;
    assign loader_done               = done_q;
    assign err_dim                   = err_dim_q;
    assign err_ovf                   = err_ovf_q;
    assign loader_sram_write_address = addr_q;
    assign loader_sram_write_data    = data_q;
    assign loader_sram_write_enable  = we_q;

endmodule
